aes_dec_key_sched: RTL and testbench

// - Round-key supplier for the AES-128 decryption core: expands a 128-bit cipher key once, then serves round keys in reverse order (10 down to 0).
// - Sits between the key input and the decryption datapath in the encrypt->decrypt chain. The decryption core pulls one key per request instead of running its own schedule.
// - Expansion is iterative, one round key per clock, using the team's forward S-box for SubWord.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_subword.sv | 14 +
 rtl/aes_dec_key_sched.sv | 186 ++++++++++++++++++
 tb/tb_aes_dec_key_sched.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 decryption round-key scheduler:
// state encoding, round-key type, Rcon table and forward S-box table.
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;

    typedef logic [KEY_W-1:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward AES S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, single byte, combinational table lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_subword.sv
// AES SubWord: applies the forward S-box to each byte of a 32-bit word.
module aes_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (word_i[8*i +: 8]),
            .byte_o (word_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 round-key supplier for the decryption core: expands a key one round per
// clock, then serves round keys 10..0 on request. KEY_CACHE_EN skips re-expanding an unchanged key.
module aes_dec_key_sched #(
    parameter int unsigned NR    = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  aes_pkg::round_key_t keyin,
    output logic                busy,
    output logic                ready,
    input  logic                rk_req,
    output logic                rk_valid,
    output aes_pkg::round_key_t rk_out,
    output logic [IDX_W-1:0]    rk_idx,
    output logic                rk_last
);
    import aes_pkg::*;

    if (NR != 10) begin : g_nr_unsupported
        $error("aes_dec_key_sched: only NR=10 (AES-128) is supported");
    end

    localparam logic [IDX_W-1:0] LAST_RND  = IDX_W'(NR);
    localparam logic [IDX_W-1:0] FIRST_RND = IDX_W'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               tbl_valid_q, tbl_valid_d;
    round_key_t         rk_q [0:NR];

    logic               busy_d, ready_d, rk_valid_d, rk_last_d;
    round_key_t         rk_out_d;
    logic [IDX_W-1:0]   rk_idx_d;

    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_widx;
    round_key_t         tbl_wdata;

    logic               cache_hit;
    round_key_t         prev_key, next_key;
    logic [WORD_W-1:0]  sub_in, sub_out, temp;
    logic [WORD_W-1:0]  w0, w1, w2, w3;

    // One AES-128 key-schedule step from the previous round key.
    assign prev_key = rk_q[IDX_W'(cnt_q - FIRST_RND)];
    assign sub_in   = {prev_key[23:0], prev_key[31:24]};

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    assign temp     = sub_out ^ {RCON[cnt_q], 24'h0};
    assign w0       = prev_key[127:96] ^ temp;
    assign w1       = prev_key[95:64]  ^ w0;
    assign w2       = prev_key[63:32]  ^ w1;
    assign w3       = prev_key[31:0]   ^ w2;
    assign next_key = {w0, w1, w2, w3};

`ifdef KEY_CACHE_EN
    round_key_t cache_q;

    // Copy of the key behind the current table; only trusted while the table is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_q <= '0;
        end else if (key_load) begin
            cache_q <= keyin;
        end
    end

    assign cache_hit = tbl_valid_q && (keyin == cache_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (key_load) begin
            state_d = cache_hit ? READY : EXPAND;
        end else begin
            case (state_q)
                EXPAND:  if (cnt_q == LAST_RND) state_d = READY;
                default: state_d = state_q;
            endcase
        end
    end

    // Counters, table write port and registered outputs; key_load overrides everything.
    always_comb begin
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        tbl_valid_d = tbl_valid_q;
        busy_d      = busy;
        ready_d     = ready;
        rk_valid_d  = 1'b0;
        rk_last_d   = 1'b0;
        rk_out_d    = rk_out;
        rk_idx_d    = rk_idx;
        tbl_we      = 1'b0;
        tbl_widx    = cnt_q;
        tbl_wdata   = next_key;

        if (key_load) begin
            ptr_d = LAST_RND;
            if (cache_hit) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end else begin
                busy_d      = 1'b1;
                ready_d     = 1'b0;
                tbl_valid_d = 1'b0;
                cnt_d       = FIRST_RND;
                tbl_we      = 1'b1;
                tbl_widx    = '0;
                tbl_wdata   = keyin;
            end
        end else begin
            case (state_q)
                EXPAND: begin
                    tbl_we = 1'b1;
                    cnt_d  = cnt_q + FIRST_RND;
                    if (cnt_q == LAST_RND) begin
                        busy_d      = 1'b0;
                        ready_d     = 1'b1;
                        tbl_valid_d = 1'b1;
                        ptr_d       = LAST_RND;
                    end
                end
                READY: begin
                    if (rk_req && tbl_valid_q) begin
                        rk_valid_d = 1'b1;
                        rk_out_d   = rk_q[ptr_q];
                        rk_idx_d   = ptr_q;
                        rk_last_d  = (ptr_q == '0);
                        ptr_d      = (ptr_q == '0) ? LAST_RND : ptr_q - FIRST_RND;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            ptr_q       <= LAST_RND;
            tbl_valid_q <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            rk_valid    <= 1'b0;
            rk_last     <= 1'b0;
            rk_out      <= '0;
            rk_idx      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            tbl_valid_q <= tbl_valid_d;
            busy        <= busy_d;
            ready       <= ready_d;
            rk_valid    <= rk_valid_d;
            rk_last     <= rk_last_d;
            rk_out      <= rk_out_d;
            rk_idx      <= rk_idx_d;
        end
    end

    // Key table storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            rk_q[tbl_widx] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: a FIPS-197 style key-expansion model with a
// computed S-box predicts every served round key; a monitor checks each rk_valid pulse.
module tb_aes_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] keyin = '0;
    logic         busy, ready, rk_req, rk_valid, rk_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef KEY_CACHE_EN
    localparam int CACHE_LAT = 0;
`else
    localparam int CACHE_LAT = 10;
`endif

    typedef struct {
        int           cyc;
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } exp_t;

    exp_t         sbq[$];
    logic [127:0] m_tab [11];
    int           m_ptr = 10;
    logic [7:0]   sb [256];

    aes_dec_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .keyin    (keyin),
        .busy     (busy),
        .ready    (ready),
        .rk_req   (rk_req),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[b] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        m_ptr = 10;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},     128'(busy),     128'(0));
        chk({tag, "_ready"},    128'(ready),    128'(0));
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_rk_last"},  128'(rk_last),  128'(0));
        chk({tag, "_rk_idx"},   128'(rk_idx),   128'(0));
        chk({tag, "_rk_out"},   rk_out,         128'(0));
    endtask

    // Called just after the key_load edge; counts cycles until ready, bounded.
    task automatic wait_ready(input logic [127:0] k, input int exp_cycles);
        int n = 0;
        int nb = 0;
        while (!ready && n < 40) begin
            if (busy) nb++;
            tick();
            n++;
        end
        chk("ready_latency", 128'(n), 128'(exp_cycles));
        chk("busy_cycles", 128'(nb), 128'(exp_cycles));
        model_expand(k);
    endtask

    task automatic load_key(input logic [127:0] k, input int exp_cycles);
        key_load = 1'b1;
        keyin    = k;
        tick();
        key_load = 1'b0;
        keyin    = {$urandom, $urandom, $urandom, $urandom};
        wait_ready(k, exp_cycles);
    endtask

    task automatic request(input int n, input bit rnd);
        exp_t e;
        bit   r;
        for (int i = 0; i < n; i++) begin
            r = rnd ? bit'($urandom % 2) : 1'b1;
            rk_req = r;
            if (r) begin
                e.cyc  = cyc + 1;
                e.idx  = 4'(m_ptr);
                e.key  = m_tab[m_ptr];
                e.last = (m_ptr == 0);
                sbq.push_back(e);
                m_ptr  = (m_ptr == 0) ? 10 : m_ptr - 1;
            end
            tick();
        end
        rk_req = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    endtask

    // Monitor: every rk_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && rk_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rk_valid: got idx=%0d key=%h, expected no output", rk_idx, rk_out);
            end else begin
                e = sbq.pop_front();
                if (rk_idx !== e.idx || rk_out !== e.key || rk_last !== e.last || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL round_key: got idx=%0d key=%h last=%b cyc=%0d, expected idx=%0d key=%h last=%b cyc=%0d",
                             rk_idx, rk_out, rk_last, cyc, e.idx, e.key, e.last, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [127:0] k;
        rk_req = 1'b0;
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        tick();

        // FIPS-197 key: model sanity against published values, then serve and wrap.
        load_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 10);
        chk("fips_rk10", m_tab[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        chk("fips_rk1",  m_tab[1],  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        chk("fips_rk0",  m_tab[0],  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
        request(11, 1'b0);
        request(12, 1'b0);

        load_key(128'h00010203_04050607_08090a0b_0c0d0e0f, 10);
        chk("seq_key_rk10", m_tab[10], 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);
        request(11, 1'b0);

        // Requests during expansion are ignored; a second load at E5 restarts.
        key_load = 1'b1;
        keyin    = {$urandom, $urandom, $urandom, $urandom};
        tick();
        key_load = 1'b0;
        rk_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("req_in_expand", 128'(rk_valid), 128'(0));
        end
        rk_req = 1'b0;
        load_key({$urandom, $urandom, $urandom, $urandom}, 10);
        request(11, 1'b0);

        // key_load beats rk_req mid-sequence.
        request(3, 1'b0);
        k        = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1;
        rk_req   = 1'b1;
        keyin    = k;
        tick();
        key_load = 1'b0;
        rk_req   = 1'b0;
        chk("load_req_rk_valid", 128'(rk_valid), 128'(0));
        chk("load_req_busy",     128'(busy),     128'(1));
        chk("load_req_ready",    128'(ready),    128'(0));
        wait_ready(k, 10);
        request(11, 1'b0);

        // Reloading the same key while the table is valid.
        request(2, 1'b0);
        load_key(k, CACHE_LAT);
        chk("reload_busy", 128'(busy), 128'(0));
        request(11, 1'b0);

        for (int t = 0; t < 3; t++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, 10);
            request(30, 1'b1);
        end

        // Asynchronous reset mid-expansion and mid-serving.
        k        = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1;
        keyin    = k;
        tick();
        key_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_zero("rst_expand");
        tick();
        rst = 1'b1;
        tick();
        load_key(k, 10);
        request(4, 1'b0);
        rst = 1'b0;
        #1;
        chk_zero("rst_ready");
        tick();
        rst = 1'b1;
        tick();
        load_key(k, 10);
        request(11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
